// File: rtl/traffic_packet_injector_pkg.sv
// Shared types for the Hermes packet injector: FSM states, descriptor layout
// and payload field positions.
package traffic_packet_injector_pkg;

    typedef enum logic [1:0] {IDLE, HDR, SIZE, PAYLOAD} state_e;

    localparam logic [31:0] PLD_SVC    = 32'd0;
    localparam logic [31:0] PLD_TASK   = 32'd1;
    localparam logic [31:0] PLD_CONS   = 32'd2;
    localparam logic [31:0] PLD_STREAM = 32'd3;

    typedef struct packed {
        logic [15:0] tgt;
        logic [31:0] size;
        logic [31:0] svc;
        logic [15:0] task_id;
        logic [15:0] cons;
    } desc_t;

endpackage

// File: rtl/traffic_packet_injector_if.sv
// Descriptor, payload stream and Hermes link signals of the packet injector.
interface traffic_packet_injector_if #(
    parameter int FLIT_SIZE = 32
);
    logic                 desc_valid_i;
    logic                 desc_ready_o;
    logic [15:0]          desc_tgt_i;
    logic [31:0]          desc_size_i;
    logic [31:0]          desc_svc_i;
    logic [15:0]          desc_task_i;
    logic [15:0]          desc_cons_i;
    logic                 pld_valid_i;
    logic                 pld_ready_o;
    logic [FLIT_SIZE-1:0] pld_data_i;
    logic                 tx_o;
    logic [FLIT_SIZE-1:0] data_o;
    logic                 credit_i;

    modport slave (
        input  desc_valid_i, desc_tgt_i, desc_size_i, desc_svc_i, desc_task_i, desc_cons_i,
        input  pld_valid_i, pld_data_i, credit_i,
        output desc_ready_o, pld_ready_o, tx_o, data_o
    );

    modport master (
        output desc_valid_i, desc_tgt_i, desc_size_i, desc_svc_i, desc_task_i, desc_cons_i,
        output pld_valid_i, pld_data_i, credit_i,
        input  desc_ready_o, pld_ready_o, tx_o, data_o
    );
endinterface

// File: rtl/traffic_packet_injector.sv
// Serializes one packet descriptor plus streamed payload onto a Hermes port
// under credit flow control; reports header tick, link occupancy and packet count.
module traffic_packet_injector
    import traffic_packet_injector_pkg::*;
#(
    parameter int          FLIT_SIZE = 32,
    parameter logic [15:0] ADDRESS   = 16'h0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    traffic_packet_injector_if.slave link,
    input  logic [63:0] tick_cntr_i,
    output logic [15:0] address_o,
    output logic        done_o,
    output logic [63:0] hdr_tick_o,
    output logic [63:0] occupancy_o,
    output logic [31:0] pkt_cnt_o
);

    state_e               state, state_nxt;
    desc_t                desc;
    logic [31:0]          idx;
    logic [63:0]          occ;
    logic                 tx, xfer, last_xfer, in_stream;
    logic [FLIT_SIZE-1:0] data;

    assign address_o = ADDRESS;
    assign in_stream = (state == PAYLOAD) && (idx >= PLD_STREAM);
    assign xfer      = tx && link.credit_i;
    assign last_xfer = xfer && (((state == SIZE) && (desc.size == '0)) ||
                                ((state == PAYLOAD) && (idx == desc.size - 32'd1)));

    always_comb begin
        state_nxt = state;
        tx        = 1'b0;
        data      = '0;
        case (state)
            IDLE: if (link.desc_valid_i) state_nxt = HDR;
            HDR: begin
                tx   = 1'b1;
                data = FLIT_SIZE'(desc.tgt);
                if (link.credit_i) state_nxt = SIZE;
            end
            SIZE: begin
                tx   = 1'b1;
                data = FLIT_SIZE'(desc.size);
                if (link.credit_i) state_nxt = (desc.size == '0) ? IDLE : PAYLOAD;
            end
            PAYLOAD: begin
                if (idx == PLD_SVC) begin
                    tx   = 1'b1;
                    data = FLIT_SIZE'(desc.svc);
                end else if (idx == PLD_TASK) begin
                    tx   = 1'b1;
                    data = FLIT_SIZE'(desc.task_id);
                end else if (idx == PLD_CONS) begin
                    tx   = 1'b1;
                    data = FLIT_SIZE'(desc.cons);
                end else begin
                    tx   = link.pld_valid_i;
                    data = link.pld_data_i;
                end
                if (last_xfer) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign link.desc_ready_o = (state == IDLE);
    assign link.tx_o         = tx;
    assign link.data_o       = data;
    // A stream flit is consumed only when it actually crosses the link.
    assign link.pld_ready_o  = in_stream && link.pld_valid_i && link.credit_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            desc        <= '0;
            idx         <= '0;
            occ         <= '0;
            done_o      <= 1'b0;
            hdr_tick_o  <= '0;
            occupancy_o <= '0;
            pkt_cnt_o   <= '0;
        end else begin
            state  <= state_nxt;
            done_o <= last_xfer;
            if ((state == IDLE) && link.desc_valid_i) begin
                desc.tgt     <= link.desc_tgt_i;
                desc.size    <= link.desc_size_i;
                desc.svc     <= link.desc_svc_i;
                desc.task_id <= link.desc_task_i;
                desc.cons    <= link.desc_cons_i;
            end
            // The header cycle counts as the first occupied cycle; stalls after it count too.
            if ((state == HDR) && xfer) begin
                hdr_tick_o <= tick_cntr_i;
                occ        <= 64'd1;
            end else if (state != IDLE) begin
                occ <= occ + 64'd1;
            end
            if ((state == SIZE) && xfer) idx <= '0;
            else if ((state == PAYLOAD) && xfer) idx <= idx + 32'd1;
            if (last_xfer) begin
                occupancy_o <= occ + 64'd1;
                pkt_cnt_o   <= pkt_cnt_o + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_traffic_packet_injector.sv
// Directed bench for traffic_packet_injector: flit order, stalls, gaps,
// back-to-back packets, counter wrap and mid-packet reset.
module tb_traffic_packet_injector;
    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] tick = 64'd1000;
    logic [15:0] address;
    logic        done;
    logic [63:0] hdr_tick, occupancy;
    logic [31:0] pkt_cnt;
    logic        s_en;
    logic [31:0] sidx = '0;
    int          n_vec = 0, n_err = 0;
    logic [31:0] xq[$];
    int          pr_cnt = 0;

    traffic_packet_injector_if #(.FLIT_SIZE(32)) link ();

    traffic_packet_injector #(.FLIT_SIZE(32), .ADDRESS(16'h0042)) dut (
        .clk_i(clk), .rst_i(rst), .link(link), .tick_cntr_i(tick),
        .address_o(address), .done_o(done), .hdr_tick_o(hdr_tick),
        .occupancy_o(occupancy), .pkt_cnt_o(pkt_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) tick <= tick + 64'd1;

    // stream source: word n of the stream is A000_0000 + n
    assign link.pld_valid_i = s_en;
    assign link.pld_data_i  = 32'hA000_0000 | sidx;
    always @(posedge clk) if (link.pld_valid_i && link.pld_ready_o) sidx <= sidx + 32'd1;

    always @(negedge clk) begin
        if (link.tx_o && link.credit_i) xq.push_back(link.data_o);
        if (link.pld_ready_o) pr_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic send_desc(input logic [15:0] tgt, input logic [31:0] size,
                             input logic [31:0] svc, input logic [15:0] tsk, input logic [15:0] cons);
        link.desc_tgt_i  = tgt;
        link.desc_size_i = size;
        link.desc_svc_i  = svc;
        link.desc_task_i = tsk;
        link.desc_cons_i = cons;
        link.desc_valid_i = 1'b1;
        @(negedge clk);
        chk("desc_ready before accept", link.desc_ready_o, 1);
        next();
        link.desc_valid_i = 1'b0;
    endtask

    // k counts cycles since the accept edge; returns at the negedge of the done cycle
    task automatic wait_done(input string tag, input int k0, output int k);
        k = k0;
        forever begin
            @(negedge clk);
            if (done) break;
            if (k >= 60) begin
                chk({tag, " done timeout"}, 0, 1);
                break;
            end
            next();
            k++;
        end
    endtask

    task automatic chk_flits(input string tag, input int base, input logic [31:0] exp[$]);
        chk({tag, " flit count"}, 64'(xq.size() - base), 64'(exp.size()));
        for (int i = 0; i < exp.size(); i++)
            if (base + i < xq.size())
                chk($sformatf("%s flit%0d", tag, i), xq[base+i], exp[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, base, prb, dcnt;
        logic [31:0] sb;
        logic [63:0] exp_tick;
        logic [31:0] e[$];

        rst = 1'b1;
        s_en = 1'b0;
        link.credit_i = 1'b1;
        link.desc_valid_i = 1'b0;
        link.desc_tgt_i = '0; link.desc_size_i = '0; link.desc_svc_i = '0;
        link.desc_task_i = '0; link.desc_cons_i = '0;
        next(); next();
        rst = 1'b0;
        @(negedge clk);
        chk("rst desc_ready", link.desc_ready_o, 1);
        chk("rst tx", link.tx_o, 0);
        chk("rst pld_ready", link.pld_ready_o, 0);
        chk("rst done", done, 0);
        chk("rst data", link.data_o, 0);
        chk("rst hdr_tick", hdr_tick, 0);
        chk("rst occupancy", occupancy, 0);
        chk("rst pkt_cnt", pkt_cnt, 0);
        chk("address", address, 16'h0042);
        next();

        // 1: size 5, continuous credit, two stream flits
        base = xq.size(); s_en = 1'b1;
        send_desc(16'h0012, 32'd5, 32'hCAFE_0001, 16'h0007, 16'h0009);
        @(negedge clk);
        chk("t1 hdr tx", link.tx_o, 1);
        chk("t1 hdr data", link.data_o, 32'h12);
        chk("t1 ready low", link.desc_ready_o, 0);
        next();
        wait_done("t1", 2, k);
        chk("t1 done cycle", 64'(k), 8);
        chk("t1 occupancy", occupancy, 7);
        chk("t1 pkt_cnt", pkt_cnt, 1);
        chk("t1 ready back", link.desc_ready_o, 1);
        e = '{32'h12, 32'd5, 32'hCAFE_0001, 32'h7, 32'h9, 32'hA000_0000, 32'hA000_0001};
        chk_flits("t1", base, e);
        next();
        @(negedge clk);
        chk("t1 done pulse", done, 0);
        s_en = 1'b0;
        next();

        // 2: credit withheld for 3 cycles on the size flit
        base = xq.size(); s_en = 1'b1;
        send_desc(16'h0012, 32'd5, 32'hCAFE_0001, 16'h0007, 16'h0009);
        @(negedge clk);
        exp_tick = tick;
        next();
        link.credit_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("t2 stall data%0d", i), link.data_o, 32'd5);
            chk($sformatf("t2 stall tx%0d", i), link.tx_o, 1);
            next();
        end
        link.credit_i = 1'b1;
        wait_done("t2", 5, k);
        chk("t2 done cycle", 64'(k), 11);
        chk("t2 occupancy", occupancy, 10);
        chk("t2 hdr_tick", hdr_tick, exp_tick);
        chk("t2 pkt_cnt", pkt_cnt, 2);
        e = '{32'h12, 32'd5, 32'hCAFE_0001, 32'h7, 32'h9, 32'hA000_0002, 32'hA000_0003};
        chk_flits("t2", base, e);
        s_en = 1'b0;
        next();

        // 3: size 0 and size 2; offered stream data must be ignored
        base = xq.size(); prb = pr_cnt; sb = sidx; s_en = 1'b1;
        send_desc(16'h0021, 32'd0, 32'h1111_1111, 16'h0001, 16'h0002);
        wait_done("t3a", 1, k);
        chk("t3a done cycle", 64'(k), 3);
        chk("t3a occupancy", occupancy, 2);
        chk("t3a pkt_cnt", pkt_cnt, 3);
        e = '{32'h21, 32'd0};
        chk_flits("t3a", base, e);
        next();
        base = xq.size();
        send_desc(16'h0033, 32'd2, 32'h5EC0_0002, 16'h0011, 16'h0022);
        wait_done("t3b", 1, k);
        chk("t3b done cycle", 64'(k), 5);
        chk("t3b pkt_cnt", pkt_cnt, 4);
        e = '{32'h33, 32'd2, 32'h5EC0_0002, 32'h11};
        chk_flits("t3b", base, e);
        chk("t3 pld_ready never", 64'(pr_cnt - prb), 0);
        chk("t3 stream untouched", sidx, sb);
        s_en = 1'b0;
        next();

        // 4: stream not valid for 4 cycles at idx 3
        base = xq.size();
        send_desc(16'h0044, 32'd4, 32'h5EC0_0004, 16'h0041, 16'h0042);
        repeat (5) next();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("t4 gap tx%0d", i), link.tx_o, 0);
            chk($sformatf("t4 gap pld_ready%0d", i), link.pld_ready_o, 0);
            next();
        end
        s_en = 1'b1;
        wait_done("t4", 10, k);
        s_en = 1'b0;
        chk("t4 done cycle", 64'(k), 11);
        chk("t4 occupancy", occupancy, 10);
        chk("t4 pkt_cnt", pkt_cnt, 5);
        e = '{32'h44, 32'd4, 32'h5EC0_0004, 32'h41, 32'h42, 32'hA000_0004};
        chk_flits("t4", base, e);
        next();

        // 5: back-to-back descriptors after a fresh reset
        rst = 1'b1; next(); rst = 1'b0;
        link.desc_tgt_i = 16'h0051; link.desc_size_i = 32'd1; link.desc_svc_i = 32'h5100_0000;
        link.desc_task_i = 16'h0001; link.desc_cons_i = 16'h0002;
        link.desc_valid_i = 1'b1;
        next();
        link.desc_tgt_i = 16'h0052; link.desc_size_i = 32'd0;
        @(negedge clk);
        chk("t5 hdr1", link.data_o, 32'h51);
        next(); next();
        @(negedge clk);
        chk("t5 svc1", link.data_o, 32'h5100_0000);
        next();
        @(negedge clk);
        chk("t5 done1", done, 1);
        chk("t5 idle tx", link.tx_o, 0);
        chk("t5 idle ready", link.desc_ready_o, 1);
        chk("t5 pkt_cnt1", pkt_cnt, 1);
        next();
        link.desc_valid_i = 1'b0;
        @(negedge clk);
        chk("t5 hdr2 tx", link.tx_o, 1);
        chk("t5 hdr2", link.data_o, 32'h52);
        chk("t5 hdr2 ready", link.desc_ready_o, 0);
        next();
        wait_done("t5b", 2, k);
        chk("t5b done cycle", 64'(k), 3);
        chk("t5 pkt_cnt2", pkt_cnt, 2);
        next();

        // packet counter wrap
        force dut.pkt_cnt_o = 32'hFFFF_FFFF;
        next();
        release dut.pkt_cnt_o;
        @(negedge clk);
        chk("wrap preload", pkt_cnt, 32'hFFFF_FFFF);
        next();
        send_desc(16'h0061, 32'd0, 32'h0, 16'h0, 16'h0);
        wait_done("wrap", 1, k);
        chk("wrap pkt_cnt", pkt_cnt, 0);
        next();

        // 6: reset during payload idx 1
        send_desc(16'h0071, 32'd5, 32'h7100_0000, 16'h0711, 16'h0712);
        next(); next(); next();
        @(negedge clk);
        chk("t6 task flit", link.data_o, 32'h711);
        rst = 1'b1;
        next();
        rst = 1'b0;
        @(negedge clk);
        chk("t6 tx", link.tx_o, 0);
        chk("t6 ready", link.desc_ready_o, 1);
        chk("t6 done", done, 0);
        chk("t6 data", link.data_o, 0);
        chk("t6 pld_ready", link.pld_ready_o, 0);
        chk("t6 pkt_cnt", pkt_cnt, 0);
        chk("t6 occupancy", occupancy, 0);
        chk("t6 hdr_tick", hdr_tick, 0);
        dcnt = 0;
        repeat (6) begin
            next();
            @(negedge clk);
            if (done || link.tx_o) dcnt++;
        end
        chk("t6 no done/tx after reset", 64'(dcnt), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
